div_unit: RTL

- Iterative RV32M divide unit in the execute stage, fed by the register file read ports (rs1/rs2 values).
- Produces a quotient or remainder plus the destination register index. Writeback logic drives these into the register file write port.
- Multi-cycle: stalls the pipeline via busy; result qualified by a one-cycle done pulse.

---
 rtl/div_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative RV32M divider (DIV/DIVU/REM/REMU), restoring
//               algorithm, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs1_val,
    input  logic [DATA_WIDTH-1:0] rs2_val,
    input  logic [4:0]            rd_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [4:0]            rd_out
);

    localparam int c_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [DATA_WIDTH-1:0] c_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] c_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [c_CNT_W-1:0]    c_LAST = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0]    c_ONE  = c_CNT_W'(1);

    logic [1:0]            r_state;
    logic                  r_rem_sel;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [DATA_WIDTH-1:0] r_dq;        // dividend shifts out MSB-first, quotient shifts in
    logic [DATA_WIDTH-1:0] r_divisor;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_result;
    logic [4:0]            r_rd;

    // Operand preparation for the accept edge
    logic                  w_signed;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic                  w_div0;
    logic                  w_ovf;
    logic [DATA_WIDTH-1:0] w_special_res;

    assign w_signed      = ~op[0];
    assign w_a_neg       = w_signed & rs1_val[DATA_WIDTH-1];
    assign w_b_neg       = w_signed & rs2_val[DATA_WIDTH-1];
    assign w_a_mag       = w_a_neg ? -rs1_val : rs1_val;
    assign w_b_mag       = w_b_neg ? -rs2_val : rs2_val;
    assign w_div0        = (rs2_val == '0);
    assign w_ovf         = w_signed & (rs1_val == c_MIN) & (rs2_val == c_ONES);
    // Divide-by-zero wins over overflow; both bypass the iteration entirely
    assign w_special_res = w_div0 ? (op[1] ? rs1_val : c_ONES)
                                  : (op[1] ? '0 : c_MIN);

    // One restoring step
    logic [DATA_WIDTH:0]   w_rem_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_rem_next;
    logic [DATA_WIDTH-1:0] w_dq_next;
    logic [DATA_WIDTH-1:0] w_sel;
    logic                  w_neg;
    logic [DATA_WIDTH-1:0] w_final;

    assign w_rem_shift = {r_rem, r_dq[DATA_WIDTH-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_divisor};
    assign w_ge        = (w_rem_shift >= {1'b0, r_divisor});
    assign w_rem_next  = w_ge ? w_diff[DATA_WIDTH-1:0] : w_rem_shift[DATA_WIDTH-1:0];
    assign w_dq_next   = {r_dq[DATA_WIDTH-2:0], w_ge};
    assign w_sel       = r_rem_sel ? w_rem_next : w_dq_next;
    assign w_neg       = r_rem_sel ? r_neg_r : r_neg_q;
    assign w_final     = w_neg ? -w_sel : w_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_rem_sel <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dq      <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_rd      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_rem_sel <= op[1];
                        r_rd      <= rd_in;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_dq      <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= c_DONE;
                        end else begin
                            r_state  <= c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    r_dq  <= w_dq_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        r_result <= w_final;
                        r_state  <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state != c_IDLE);
    assign done   = (r_state == c_DONE);
    assign result = r_result;
    assign rd_out = r_rd;

endmodule
`default_nettype wire
